my_fruit_splitter: RTL and testbench

MY_FRUIT_SPLITTER -- requirements
Module: my_fruit_splitter

---
 rtl/my_fruit_splitter.sv | 126 ++++++++++++
 tb/tb_my_fruit_splitter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/my_fruit_splitter.sv
// Packet router: steers whole packets from one stream input to port x or y, with a
// one-entry register buffer per output. Optional beat counters under FRUIT_SPLITTER_COUNT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | between packets; each beat is routed by s0
// ROUTE_X | inside a packet locked to port x; s0 ignored until last beat
// ROUTE_Y | inside a packet locked to port y; s0 ignored until last beat
module my_fruit_splitter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             s0,
    output logic [WIDTH-1:0] x_data,
    output logic             x_valid,
    output logic             x_last,
    input  logic             x_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             y_last,
    input  logic             y_ready
`ifdef FRUIT_SPLITTER_COUNT_EN
    ,
    output logic [15:0]      x_count,
    output logic [15:0]      y_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_X = 2'd1,
        ROUTE_Y = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   tgt_y;
    logic   accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_nxt = s0 ? ROUTE_Y : ROUTE_X;
                end
            end
            ROUTE_X, ROUTE_Y: begin
                if (accept && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Readiness looks only at the target buffer, so a stalled non-target port never blocks input.
    always_comb begin
        tgt_y    = (state == IDLE) ? s0 : (state == ROUTE_Y);
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = tgt_y ? (!y_valid || y_ready) : (!x_valid || x_ready);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_data  <= '0;
            x_last  <= 1'b0;
            x_valid <= 1'b0;
        end else if (accept && !tgt_y) begin
            x_data  <= in_data;
            x_last  <= in_last;
            x_valid <= 1'b1;
        end else if (x_ready) begin
            x_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data  <= '0;
            y_last  <= 1'b0;
            y_valid <= 1'b0;
        end else if (accept && tgt_y) begin
            y_data  <= in_data;
            y_last  <= in_last;
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef FRUIT_SPLITTER_COUNT_EN
    // Delivered-beat counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_count <= '0;
            y_count <= '0;
        end else begin
            if (x_valid && x_ready && (x_count != 16'hFFFF)) begin
                x_count <= x_count + 16'd1;
            end
            if (y_valid && y_ready && (y_count != 16'hFFFF)) begin
                y_count <= y_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_my_fruit_splitter.sv
// Bench for my_fruit_splitter: packet-level queue model checked every cycle plus directed
// scenarios with literal expectations. Counter checks are built with FRUIT_SPLITTER_COUNT_EN.
module tb_my_fruit_splitter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             s0;
    logic [WIDTH-1:0] x_data, y_data;
    logic             x_valid, y_valid, x_last, y_last;
    logic             x_ready, y_ready;
`ifdef FRUIT_SPLITTER_COUNT_EN
    logic [15:0]      x_count, y_count;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    my_fruit_splitter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .s0       (s0),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_last   (x_last),
        .x_ready  (x_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_last   (y_last),
        .y_ready  (y_ready)
`ifdef FRUIT_SPLITTER_COUNT_EN
        ,
        .x_count  (x_count),
        .y_count  (y_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: per-port FIFO of beats accepted but not yet delivered, plus packet lock.
    logic [WIDTH:0] xq[$];
    logic [WIDTH:0] yq[$];
    bit             locked   = 0;
    bit             lock_y   = 0;

    always @(negedge clk) begin
        bit tgt_y, exp_rdy, pop_x, pop_y;
        if (!rst_n) begin
            xq.delete();
            yq.delete();
            locked = 0;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_x_valid",  {31'd0, x_valid},  32'd0);
            chk("rst_y_valid",  {31'd0, y_valid},  32'd0);
            chk("rst_x_data",   {24'd0, x_data},   32'd0);
            chk("rst_y_data",   {24'd0, y_data},   32'd0);
        end else begin
            tgt_y   = locked ? lock_y : s0;
            exp_rdy = tgt_y ? (yq.size() == 0 || y_ready) : (xq.size() == 0 || x_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("x_valid", {31'd0, x_valid}, {31'd0, xq.size() != 0});
            chk("y_valid", {31'd0, y_valid}, {31'd0, yq.size() != 0});
            if (xq.size() != 0) chk("x_beat", {23'd0, x_last, x_data}, {23'd0, xq[0]});
            if (yq.size() != 0) chk("y_beat", {23'd0, y_last, y_data}, {23'd0, yq[0]});
            pop_x = (xq.size() != 0) && x_ready;
            pop_y = (yq.size() != 0) && y_ready;
            if (pop_x) void'(xq.pop_front());
            if (pop_y) void'(yq.pop_front());
            if (in_valid && exp_rdy) begin
                if (tgt_y) yq.push_back({in_last, in_data});
                else       xq.push_back({in_last, in_data});
                if (in_last) locked = 0;
                else if (!locked) begin
                    locked = 1;
                    lock_y = s0;
                end
            end
        end
    end

    // Presents one beat and returns #1 after the edge that accepts it; in_valid stays high.
    task automatic send(input logic [7:0] d, input logic l, input logic sel, output int waits);
        in_data  = d;
        in_last  = l;
        s0       = sel;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 20) begin
                chk("accept_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        s0       = 1'b0;
        x_ready  = 1'b1;
        y_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x_valid", {31'd0, x_valid}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Single-beat packet to x, then confirm FSM stayed IDLE by routing next beat to y.
        send(8'hA5, 1'b1, 1'b0, w);
        chk("single_x_valid", {31'd0, x_valid}, 32'd1);
        chk("single_x_data",  {24'd0, x_data},  32'h0000_00A5);
        chk("single_x_last",  {31'd0, x_last},  32'd1);
        chk("single_y_valid", {31'd0, y_valid}, 32'd0);
        send(8'hB6, 1'b1, 1'b1, w);
        chk("idle_next_y_data", {24'd0, y_data}, 32'h0000_00B6);
        chk("idle_next_y_valid", {31'd0, y_valid}, 32'd1);
        idle(2);

        // Route lock: s0 toggles every beat, all beats land on y.
        for (int k = 1; k <= 4; k++) begin
            send(k[7:0], k == 4, (k % 2) == 1, w);
            chk("lock_y_data",  {24'd0, y_data},  k);
            chk("lock_y_last",  {31'd0, y_last},  {31'd0, k == 4});
            chk("lock_x_valid", {31'd0, x_valid}, 32'd0);
        end
        idle(2);

        // Back-pressure on x: first beat held, second stalls until x_ready.
        x_ready = 1'b0;
        send(8'h10, 1'b0, 1'b0, w);
        in_data = 8'h11;
        in_last = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_x_data",   {24'd0, x_data},   32'h0000_0010);
        end
        @(posedge clk);
        #1;
        x_ready = 1'b1;
        send(8'h11, 1'b1, 1'b0, w);
        chk("bp_x_data2", {24'd0, x_data}, 32'h0000_0011);
        chk("bp_x_last2", {31'd0, x_last}, 32'd1);
        idle(2);

        // Stalled y must not throttle a packet bound for x.
        y_ready = 1'b0;
        send(8'h55, 1'b1, 1'b1, w);
        for (int k = 0; k < 3; k++) begin
            send(8'h60 + k[7:0], k == 2, 1'b0, w);
            chk("indep_waits",  w, 32'd0);
            chk("indep_x_data", {24'd0, x_data}, 32'h60 + k);
            chk("indep_y_hold", {24'd0, y_data}, 32'h0000_0055);
        end
        idle(1);
        y_ready = 1'b1;
        idle(2);

        // Reset in the middle of a y packet drops buffers and the lock.
        send(8'h21, 1'b0, 1'b1, w);
        send(8'h22, 1'b0, 1'b0, w);
        chk("mid_y_data", {24'd0, y_data}, 32'h0000_0022);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_y_valid",  {31'd0, y_valid},  32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h30, 1'b1, 1'b0, w);
        chk("post_rst_x_data",  {24'd0, x_data},  32'h0000_0030);
        chk("post_rst_y_valid", {31'd0, y_valid}, 32'd0);
        idle(2);

`ifdef FRUIT_SPLITTER_COUNT_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("cnt_rst_x", {16'd0, x_count}, 32'd0);
        for (int k = 0; k < 3; k++) send(8'h70 + k[7:0], 1'b1, 1'b0, w);
        for (int k = 0; k < 2; k++) send(8'h80 + k[7:0], 1'b1, 1'b1, w);
        idle(2);
        chk("cnt_x3", {16'd0, x_count}, 32'd3);
        chk("cnt_y2", {16'd0, y_count}, 32'd2);
        for (int k = 0; k < 65540; k++) send(k[7:0], 1'b1, 1'b0, w);
        idle(2);
        chk("cnt_x_sat", {16'd0, x_count}, 32'h0000_FFFF);
        chk("cnt_y_keep", {16'd0, y_count}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
